mul_iter_unit: RTL and testbench
================================

# mul_iter_unit

Iterative multiplier for the execute stage. Accepts decoded `OP_ALU` / `F7_MUL` / `F3_MUL` operations from the decode/issue stage and returns the low 32 bits of `rs1*rs2` to writeback. The datapath is shift-and-add, with `BITS_PER_CYCLE` multiplier bits retired per cycle. Valid/ready handshakes on both sides and a kill input give pipeline flush.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits consumed per iteration. Legal values are 1, 2, 4 and 8.
- `TAG_W`, default 5: width of the destination tag (rd index).
- `clk_i` in 1: the only clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit can accept a request.
- `req_rs1_i` in 32 (`bus32_t`): multiplicand.
- `req_rs2_i` in 32 (`bus32_t`): multiplier.
- `req_tag_i` in `TAG_W`: destination tag, returned with the result.
- `kill_i` in 1: flush. Abandons any accepted or in-flight operation.
- `resp_valid_o` out 1: result available.
- `resp_ready_i` in 1: writeback accepts the result.
- `resp_data_o` out 32 (`bus32_t`): low 32 bits of the product.
- `resp_tag_o` out `TAG_W`: tag of the returned operation.

## Operation
- States: IDLE, BUSY, DONE. `N = 32/BITS_PER_CYCLE`.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i && !kill_i`:
    - latch multiplicand, multiplier and tag;
    - clear the accumulator;
    - set iteration counter = N;
    - go to BUSY.
- **BUSY**, each cycle:
  - `acc += mcand * mplier[BITS_PER_CYCLE-1:0]`, truncated to 32 bits;
  - `mcand <<= BITS_PER_CYCLE`, `mplier >>= BITS_PER_CYCLE`;
  - `count -= 1`.
  - When count reaches 0, go to DONE.
- **DONE**
  - `resp_valid_o` = 1; `resp_data_o` = acc; `resp_tag_o` = latched tag.
  - Hold all three until `resp_ready_i`, then return to IDLE.
- Arithmetic:
  - All sums are modulo 2^32. The result equals `(rs1*rs2)[31:0]` and is identical for signed and unsigned interpretation.
  - No overflow flag is produced.
- `req_ready_o` is high only in IDLE. There is no combinational path from `resp_ready_i` to `req_ready_o`.
- **Kill**, in any state: next state is IDLE, `resp_valid_o` is 0 the following cycle, and the result is discarded.
  - In IDLE, a simultaneous `req_valid_i` is not accepted.
  - In DONE with `resp_ready_i`, the response counts as not taken. Writeback must also ignore it under kill.
- Inputs are ignored outside the IDLE handshake. Operand changes while BUSY have no effect.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system):
  - state = IDLE; `req_ready_o` = 1; `resp_valid_o` = 0;
  - `resp_data_o` = 0; `resp_tag_o` = 0; counter = 0.
- Latency: request accepted at edge E0 gives `resp_valid_o` high after edge E0+N, i.e. 32 cycles for `BITS_PER_CYCLE`=1 and 8 cycles for 4.
- Throughput: one operation per N+2 cycles minimum. This is one bubble in IDLE after the response handshake.
- Reset mid-operation immediately abandons the operation. No response is produced.
- Kill is sampled at the clock edge. The effect is visible in the next cycle.

## Structure
- Add `mul_state_t` (IDLE/BUSY/DONE) to `tartaruga_pkg`. Operand and result types use the existing `bus32_t`.
- Decode gating on `OP_ALU`, `F7_MUL` and `F3_MUL` from `riscv_pkg` is done upstream. This unit performs no opcode checks.
- One sub-module: `mul_step`. It is the combinational partial-product adder for one iteration, parameterised by `BITS_PER_CYCLE`.
- Control FSM, counter and operand registers live in `mul_iter_unit`.

## Test plan
- **Basic product:** `BITS_PER_CYCLE`=1, rs1=3, rs2=5, tag=7.
  - `resp_valid_o` rises exactly 32 cycles after the accept edge.
  - data = 0x0000000F, tag = 7.
- **Wrap-around:** rs1=0xFFFFFFFF, rs2=0xFFFFFFFF gives data = 0x00000001. rs1=0x80000000, rs2=2 gives data = 0x00000000.
- **Backpressure:** rs1=0x1234, rs2=0x10 with `resp_ready_i` held low for 5 cycles.
  - data stays at 0x00012340 with `resp_valid_o` stable throughout.
  - `req_ready_o` stays 0 until the cycle after the handshake.
- **Kill mid-operation:** kill at cycle 10 of BUSY.
  - Next cycle is IDLE and no response is produced.
  - A following request rs1=7, rs2=6, tag=3 returns 42 with tag 3.
- **Kill vs. accept:** kill with `req_valid_i` in IDLE means no accept. Kill while in DONE with `resp_ready_i` clears `resp_valid_o`.
- **Reset and parameter sweep:** assert `rstn_i` low mid-BUSY.
  - All outputs are at reset values asynchronously.
  - Repeat with `BITS_PER_CYCLE`=4: random operands match the reference product with 8-cycle latency.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga execute stage: the 32-bit bus type and
// the iterative multiplier's control states.
package tartaruga_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] bus32_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Number of shift-and-add iterations needed for a full 32-bit multiplier.
    function automatic int mul_iters(input int bits_per_cycle);
        return XLEN / bits_per_cycle;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: adds mcand * mplier_bits to the accumulator,
// with the sum truncated to 32 bits.
module mul_step
    import tartaruga_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  bus32_t                    acc,
    input  bus32_t                    mcand,
    input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
    output bus32_t                    acc_next
);

    bus32_t pp [BITS_PER_CYCLE];
    bus32_t sum;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_bits[gi] ? (mcand << gi) : '0;
        end
    endgenerate

    always_comb begin
        sum = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sum = sum + pp[i];
        end
    end

    assign acc_next = sum;

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative shift-and-add multiplier returning the low 32 bits of rs1*rs2,
// with valid/ready handshakes on request and response and a kill flush.
module mul_iter_unit
    import tartaruga_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  bus32_t           req_rs1_i,
    input  bus32_t           req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output bus32_t           resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o
);

    localparam int         N     = mul_iters(BITS_PER_CYCLE);
    localparam logic [5:0] N_CNT = 6'(N);

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
            BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
            $error("mul_iter_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    mul_state_t       state_reg;
    logic [5:0]       count_reg;
    bus32_t           mcand_reg;
    bus32_t           mplier_reg;
    bus32_t           acc_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             req_ready_reg;
    logic             resp_valid_reg;
    bus32_t           acc_next;

    mul_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .acc         (acc_reg),
        .mcand       (mcand_reg),
        .mplier_bits (mplier_reg[BITS_PER_CYCLE-1:0]),
        .acc_next    (acc_next)
    );

    // The accumulator doubles as the result register; it only changes while
    // BUSY, so it is stable for the whole DONE handshake.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= MUL_IDLE;
            count_reg      <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            acc_reg        <= '0;
            tag_reg        <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
        end else if (kill_i) begin
            state_reg      <= MUL_IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                MUL_IDLE: begin
                    if (req_valid_i) begin
                        mcand_reg     <= req_rs1_i;
                        mplier_reg    <= req_rs2_i;
                        tag_reg       <= req_tag_i;
                        acc_reg       <= '0;
                        count_reg     <= N_CNT;
                        state_reg     <= MUL_BUSY;
                        req_ready_reg <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
                    count_reg  <= count_reg - 6'd1;
                    if (count_reg == 6'd1) begin
                        state_reg      <= MUL_DONE;
                        resp_valid_reg <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    if (resp_ready_i) begin
                        state_reg      <= MUL_IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= MUL_IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_data_o  = acc_reg;
    assign resp_tag_o   = tag_reg;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: unit 0 uses BITS_PER_CYCLE=1,
// unit 1 uses BITS_PER_CYCLE=4; a transaction-level model is checked every cycle.
module tb_mul_iter_unit;

    logic        clk;
    logic        rstn       [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] rs1        [2];
    logic [31:0] rs2        [2];
    logic [4:0]  tag_in     [2];
    logic        kill       [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic [4:0]  resp_tag   [2];

    int errors = 0;
    int checks = 0;

    // Model: per unit, the operation in flight and the product it must return.
    bit          m_busy  [2];
    bit          m_valid [2];
    int          m_cnt   [2];
    logic [31:0] m_data  [2];
    logic [4:0]  m_tag   [2];
    int          n_of    [2];

    mul_iter_unit #(.BITS_PER_CYCLE(1), .TAG_W(5)) dut0 (
        .clk_i        (clk),
        .rstn_i       (rstn[0]),
        .req_valid_i  (req_valid[0]),
        .req_ready_o  (req_ready[0]),
        .req_rs1_i    (rs1[0]),
        .req_rs2_i    (rs2[0]),
        .req_tag_i    (tag_in[0]),
        .kill_i       (kill[0]),
        .resp_valid_o (resp_valid[0]),
        .resp_ready_i (resp_ready[0]),
        .resp_data_o  (resp_data[0]),
        .resp_tag_o   (resp_tag[0])
    );

    mul_iter_unit #(.BITS_PER_CYCLE(4), .TAG_W(5)) dut1 (
        .clk_i        (clk),
        .rstn_i       (rstn[1]),
        .req_valid_i  (req_valid[1]),
        .req_ready_o  (req_ready[1]),
        .req_rs1_i    (rs1[1]),
        .req_rs2_i    (rs2[1]),
        .req_tag_i    (tag_in[1]),
        .kill_i       (kill[1]),
        .resp_valid_o (resp_valid[1]),
        .resp_ready_i (resp_ready[1]),
        .resp_data_o  (resp_data[1]),
        .resp_tag_o   (resp_tag[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_busy[u]  = 1'b0;
        m_valid[u] = 1'b0;
        m_cnt[u]   = 0;
        m_data[u]  = '0;
        m_tag[u]   = '0;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare every unit's outputs half a cycle later.
    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (!rstn[u]) begin
                model_reset(u);
            end else if (kill[u]) begin
                m_busy[u]  = 1'b0;
                m_valid[u] = 1'b0;
            end else if (m_busy[u]) begin
                m_cnt[u] = m_cnt[u] - 1;
                if (m_cnt[u] == 0) begin
                    m_busy[u]  = 1'b0;
                    m_valid[u] = 1'b1;
                end
            end else if (m_valid[u]) begin
                if (resp_ready[u]) m_valid[u] = 1'b0;
            end else if (req_valid[u]) begin
                m_busy[u] = 1'b1;
                m_cnt[u]  = n_of[u];
                m_data[u] = rs1[u] * rs2[u];
                m_tag[u]  = tag_in[u];
            end
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d req_ready", u), 32'(req_ready[u]), 32'(!m_busy[u] && !m_valid[u]));
            check($sformatf("u%0d resp_valid", u), 32'(resp_valid[u]), 32'(m_valid[u]));
            if (m_valid[u]) begin
                check($sformatf("u%0d resp_data", u), resp_data[u], m_data[u]);
                check($sformatf("u%0d resp_tag", u), 32'(resp_tag[u]), 32'(m_tag[u]));
            end
        end
    endtask

    task automatic do_req(input int u, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        rs1[u]       = a;
        rs2[u]       = b;
        tag_in[u]    = t;
        req_valid[u] = 1'b1;
        tick();
        req_valid[u] = 1'b0;
    endtask

    // Counts cycles from the accept edge until resp_valid is seen.
    task automatic wait_resp(input int u, input int budget, output int cyc);
        cyc = 0;
        while (!resp_valid[u] && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!resp_valid[u]) begin
            checks++;
            errors++;
            $display("FAIL u%0d timeout: no resp_valid within %0d cycles", u, budget);
        end
    endtask

    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp_data, input int exp_lat);
        int cyc;
        do_req(u, a, b, t);
        wait_resp(u, exp_lat + 8, cyc);
        check($sformatf("u%0d latency", u), 32'(cyc), 32'(exp_lat));
        check($sformatf("u%0d data %08h*%08h", u, a, b), resp_data[u], exp_data);
        check($sformatf("u%0d tag", u), 32'(resp_tag[u]), 32'(t));
        $display("u%0d op %08h * %08h tag %0d -> %08h after %0d cycles", u, a, b, t, resp_data[u], cyc);
    endtask

    initial begin
        int cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  t;
        n_of[0] = 32;
        n_of[1] = 8;
        for (int u = 0; u < 2; u++) begin
            rstn[u]       = 1'b1;
            req_valid[u]  = 1'b0;
            rs1[u]        = '0;
            rs2[u]        = '0;
            tag_in[u]     = '0;
            kill[u]       = 1'b0;
            resp_ready[u] = 1'b1;
            model_reset(u);
        end
        #1;
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        #2;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset req_ready", u), 32'(req_ready[u]), 32'h1);
            check($sformatf("u%0d reset resp_valid", u), 32'(resp_valid[u]), 32'h0);
            check($sformatf("u%0d reset resp_data", u), resp_data[u], 32'h0);
            check($sformatf("u%0d reset resp_tag", u), 32'(resp_tag[u]), 32'h0);
        end
        @(negedge clk);
        tick();
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        tick();

        // Basic product, wrap-around
        run_op(0, 32'd3, 32'd5, 5'd7, 32'h0000000F, 32);
        tick();
        run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, 32);
        tick();
        run_op(0, 32'h80000000, 32'd2, 5'd2, 32'h00000000, 32);
        tick();

        // Backpressure: result and valid held while writeback stalls
        resp_ready[0] = 1'b0;
        run_op(0, 32'h1234, 32'h10, 5'd9, 32'h00012340, 32);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("u0 bp data", resp_data[0], 32'h00012340);
            check("u0 bp valid", 32'(resp_valid[0]), 32'h1);
            check("u0 bp req_ready", 32'(req_ready[0]), 32'h0);
        end
        resp_ready[0] = 1'b1;
        tick();
        check("u0 bp ready after handshake", 32'(req_ready[0]), 32'h1);
        $display("u0 backpressure released");

        // Kill in the 10th BUSY cycle; operand changes while BUSY are ignored
        do_req(0, 32'h0000DEAD, 32'h0000BEEF, 5'd1);
        rs1[0] = 32'h55555555;
        rs2[0] = 32'hAAAAAAAA;
        for (int i = 0; i < 9; i++) tick();
        kill[0] = 1'b1;
        tick();
        kill[0] = 1'b0;
        check("u0 kill busy valid", 32'(resp_valid[0]), 32'h0);
        check("u0 kill busy ready", 32'(req_ready[0]), 32'h1);
        for (int i = 0; i < 40; i++) tick();
        $display("u0 kill mid-operation: no response");
        rs1[0] = 32'd7;
        rs2[0] = 32'd6;
        tag_in[0] = 5'd3;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        rs1[0] = 32'h01020304;
        rs2[0] = 32'hFFFF0000;
        tag_in[0] = 5'd30;
        wait_resp(0, 40, cyc);
        check("u0 after kill data", resp_data[0], 32'd42);
        check("u0 after kill tag", 32'(resp_tag[0]), 32'd3);
        check("u0 after kill latency", 32'(cyc), 32'd32);
        $display("u0 op 7 * 6 tag 3 -> %08h after %0d cycles", resp_data[0], cyc);
        tick();

        // Kill with a request in IDLE: not accepted
        rs1[0] = 32'd9;
        rs2[0] = 32'd9;
        req_valid[0] = 1'b1;
        kill[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        kill[0] = 1'b0;
        check("u0 kill idle ready", 32'(req_ready[0]), 32'h1);
        tick();
        check("u0 kill idle no valid", 32'(resp_valid[0]), 32'h0);
        $display("u0 kill vs accept: request dropped");

        // Kill in DONE with resp_ready: response withdrawn
        resp_ready[0] = 1'b0;
        run_op(0, 32'd2, 32'd3, 5'd4, 32'd6, 32);
        kill[0] = 1'b1;
        resp_ready[0] = 1'b1;
        tick();
        kill[0] = 1'b0;
        check("u0 kill done valid", 32'(resp_valid[0]), 32'h0);
        check("u0 kill done ready", 32'(req_ready[0]), 32'h1);
        $display("u0 kill in DONE: response withdrawn");
        tick();

        // Asynchronous reset mid-BUSY
        do_req(0, 32'd5, 32'd5, 5'd5);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rstn[0] = 1'b0;
        #1;
        check("u0 async rst req_ready", 32'(req_ready[0]), 32'h1);
        check("u0 async rst resp_valid", 32'(resp_valid[0]), 32'h0);
        check("u0 async rst resp_data", resp_data[0], 32'h0);
        check("u0 async rst resp_tag", 32'(resp_tag[0]), 32'h0);
        model_reset(0);
        tick();
        rstn[0] = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        $display("u0 reset mid-BUSY: no response");

        // BITS_PER_CYCLE=4: literal pins, then random operands
        run_op(1, 32'd1000, 32'd1000, 5'd11, 32'h000F4240, 8);
        tick();
        run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000001, 8);
        tick();
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            t = 5'($urandom_range(0, 31));
            run_op(1, a, b, t, a * b, 8);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
